// File: rtl/axi4_burst_master.sv
// AXI4 burst master: splits one block-transfer command into 4 KB-safe INCR bursts
// and streams beats between local valid/ready ports and DRAM, one burst in flight.
module axi4_burst_master #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned AXI_ID     = 0,
   parameter int unsigned MAX_BURST  = 128,
   parameter int unsigned LEN_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_beats,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  done,
   output logic                  err,
   output logic [ID_WIDTH-1:0]   arid_m_inf,
   output logic [ADDR_WIDTH-1:0] araddr_m_inf,
   output logic [7:0]            arlen_m_inf,
   output logic [2:0]            arsize_m_inf,
   output logic [1:0]            arburst_m_inf,
   output logic                  arvalid_m_inf,
   input  logic                  arready_m_inf,
   input  logic [ID_WIDTH-1:0]   rid_m_inf,
   input  logic [DATA_WIDTH-1:0] rdata_m_inf,
   input  logic [1:0]            rresp_m_inf,
   input  logic                  rlast_m_inf,
   input  logic                  rvalid_m_inf,
   output logic                  rready_m_inf,
   output logic [ID_WIDTH-1:0]   awid_m_inf,
   output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
   output logic [7:0]            awlen_m_inf,
   output logic [2:0]            awsize_m_inf,
   output logic [1:0]            awburst_m_inf,
   output logic                  awvalid_m_inf,
   input  logic                  awready_m_inf,
   output logic [DATA_WIDTH-1:0] wdata_m_inf,
   output logic                  wlast_m_inf,
   output logic                  wvalid_m_inf,
   input  logic                  wready_m_inf,
   input  logic [ID_WIDTH-1:0]   bid_m_inf,
   input  logic [1:0]            bresp_m_inf,
   input  logic                  bvalid_m_inf,
   output logic                  bready_m_inf
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned SIZE  = $clog2(BYTES);
   localparam int unsigned REM_W = LEN_WIDTH + 1;
   localparam int unsigned CNT_W = (REM_W > 13) ? REM_W : 13;

   typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

   state_t                state_q, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nx, ax_addr_q, burst_bytes;
   logic [REM_W-1:0]      rem_q, rem_nx, burst_n;
   logic [7:0]            len_q, len_nx, beat_q, beat_nx;
   logic [CNT_W-1:0]      page_beats, n_beats;
   logic                  done_q, done_nx, err_q, err_nx, cmd_ready_q, issue;
   logic                  arvalid_q, awvalid_q, bready_q;
   logic                  beat_last, final_burst, r_hs, w_hs;

   assign beat_last   = (beat_q == len_q);
   assign burst_n     = REM_W'(len_q) + REM_W'(1);
   assign burst_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << SIZE;
   assign final_burst = (rem_q == burst_n);
   assign r_hs        = (state_q == R) && rvalid_m_inf && rd_ready;
   assign w_hs        = (state_q == W) && wr_valid && wready_m_inf;

   // Next-state and datapath update
   always_comb begin
      state_nx = state_q;
      addr_nx  = addr_q;
      rem_nx   = rem_q;
      beat_nx  = beat_q;
      err_nx   = err_q;
      done_nx  = 1'b0;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_nx  = cmd_addr;
               rem_nx   = REM_W'(cmd_beats) + REM_W'(1);
               err_nx   = 1'b0;
               issue    = 1'b1;
               state_nx = cmd_write ? AW : AR;
            end
         end
         AR: begin
            if (arready_m_inf) begin
               beat_nx  = '0;
               state_nx = R;
            end
         end
         R: begin
            if (r_hs) begin
               // the beat counter is authoritative; a misplaced rlast only flags err
               if ((rresp_m_inf != 2'b00) || (rlast_m_inf != beat_last)) err_nx = 1'b1;
               if (beat_last) begin
                  addr_nx = addr_q + burst_bytes;
                  rem_nx  = rem_q - burst_n;
                  if (final_burst) begin
                     done_nx  = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     issue    = 1'b1;
                     state_nx = AR;
                  end
               end else begin
                  beat_nx = beat_q + 8'd1;
               end
            end
         end
         AW: begin
            if (awready_m_inf) begin
               beat_nx  = '0;
               state_nx = W;
            end
         end
         W: begin
            if (w_hs) begin
               if (beat_last) state_nx = B;
               else           beat_nx  = beat_q + 8'd1;
            end
         end
         B: begin
            if (bvalid_m_inf) begin
               if (bresp_m_inf != 2'b00) err_nx = 1'b1;
               addr_nx = addr_q + burst_bytes;
               rem_nx  = rem_q - burst_n;
               if (final_burst) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  issue    = 1'b1;
                  state_nx = AW;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Next burst length: limited by remaining beats, MAX_BURST and the 4 KB page
   always_comb begin
      page_beats = CNT_W'((13'd4096 - {1'b0, addr_nx[11:0]}) >> SIZE);
      n_beats    = CNT_W'(rem_nx);
      if (CNT_W'(MAX_BURST) < n_beats) n_beats = CNT_W'(MAX_BURST);
      if (page_beats < n_beats)        n_beats = page_beats;
      len_nx     = 8'(n_beats - CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         beat_q      <= '0;
         len_q       <= '0;
         ax_addr_q   <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         arvalid_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
      end else begin
         state_q     <= state_nx;
         addr_q      <= addr_nx;
         rem_q       <= rem_nx;
         beat_q      <= beat_nx;
         err_q       <= err_nx;
         done_q      <= done_nx;
         // ready returns one cycle after the done pulse
         cmd_ready_q <= (state_nx == IDLE) && !done_nx;
         arvalid_q   <= (state_nx == AR);
         awvalid_q   <= (state_nx == AW);
         bready_q    <= (state_nx == B);
         if (issue) begin
            ax_addr_q <= addr_nx;
            len_q     <= len_nx;
         end
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign done          = done_q;
   assign err           = err_q;

   assign arid_m_inf    = ID_WIDTH'(AXI_ID);
   assign araddr_m_inf  = ax_addr_q;
   assign arlen_m_inf   = len_q;
   assign arsize_m_inf  = 3'(SIZE);
   assign arburst_m_inf = 2'b01;
   assign arvalid_m_inf = arvalid_q;
   assign awid_m_inf    = ID_WIDTH'(AXI_ID);
   assign awaddr_m_inf  = ax_addr_q;
   assign awlen_m_inf   = len_q;
   assign awsize_m_inf  = 3'(SIZE);
   assign awburst_m_inf = 2'b01;
   assign awvalid_m_inf = awvalid_q;
   assign bready_m_inf  = bready_q;

   // Data channels are pass-through, gated by the owning state
   assign rready_m_inf  = (state_q == R) && rd_ready;
   assign rd_valid      = (state_q == R) && rvalid_m_inf;
   assign rd_data       = rdata_m_inf;
   assign rd_last       = (state_q == R) && beat_last && final_burst;
   assign wvalid_m_inf  = (state_q == W) && wr_valid;
   assign wr_ready      = (state_q == W) && wready_m_inf;
   assign wdata_m_inf   = wr_data;
   assign wlast_m_inf   = (state_q == W) && beat_last;

   logic unused_ids;
   assign unused_ids = ^{rid_m_inf, bid_m_inf};

endmodule

// File: tb/tb_axi4_burst_master.sv
// Randomized bench for axi4_burst_master: AXI slave memory model plus a burst-plan
// reference computed from the transfer rules.
module tb_axi4_burst_master;
   localparam int unsigned DW = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, cmd_valid, cmd_ready, cmd_write;
   logic [31:0]   cmd_addr;
   logic [11:0]   cmd_beats;
   logic          rd_valid, rd_ready, rd_last, wr_valid, wr_ready, done, err;
   logic [DW-1:0] rd_data, wr_data, rdata_m_inf, wdata_m_inf;
   logic [3:0]    arid_m_inf, rid_m_inf, awid_m_inf, bid_m_inf;
   logic [31:0]   araddr_m_inf, awaddr_m_inf;
   logic [7:0]    arlen_m_inf, awlen_m_inf;
   logic [2:0]    arsize_m_inf, awsize_m_inf;
   logic [1:0]    arburst_m_inf, awburst_m_inf, rresp_m_inf, bresp_m_inf;
   logic          arvalid_m_inf, arready_m_inf, rlast_m_inf, rvalid_m_inf, rready_m_inf;
   logic          awvalid_m_inf, awready_m_inf, wlast_m_inf, wvalid_m_inf, wready_m_inf;
   logic          bvalid_m_inf, bready_m_inf;

   axi4_burst_master dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .done(done), .err(err),
      .arid_m_inf(arid_m_inf), .araddr_m_inf(araddr_m_inf), .arlen_m_inf(arlen_m_inf),
      .arsize_m_inf(arsize_m_inf), .arburst_m_inf(arburst_m_inf),
      .arvalid_m_inf(arvalid_m_inf), .arready_m_inf(arready_m_inf),
      .rid_m_inf(rid_m_inf), .rdata_m_inf(rdata_m_inf), .rresp_m_inf(rresp_m_inf),
      .rlast_m_inf(rlast_m_inf), .rvalid_m_inf(rvalid_m_inf), .rready_m_inf(rready_m_inf),
      .awid_m_inf(awid_m_inf), .awaddr_m_inf(awaddr_m_inf), .awlen_m_inf(awlen_m_inf),
      .awsize_m_inf(awsize_m_inf), .awburst_m_inf(awburst_m_inf),
      .awvalid_m_inf(awvalid_m_inf), .awready_m_inf(awready_m_inf),
      .wdata_m_inf(wdata_m_inf), .wlast_m_inf(wlast_m_inf), .wvalid_m_inf(wvalid_m_inf),
      .wready_m_inf(wready_m_inf), .bid_m_inf(bid_m_inf), .bresp_m_inf(bresp_m_inf),
      .bvalid_m_inf(bvalid_m_inf), .bready_m_inf(bready_m_inf)
   );

   typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;

   burst_t        exp_ax[$];
   logic [DW-1:0] mem [int unsigned];
   logic [DW-1:0] wq[$];
   int            total = 0, bad = 0;
   int            err_burst = -1, b_cnt = 0, cyc = 0, last_hs = 0;
   int            r_left = 0, w_left = 0, rd_idx = 0, wr_idx = 0, wr_src = 0, done_cnt = 0;
   int            nbeats = 0;
   logic [31:0]   base = '0, r_addr = '0, w_addr = '0;
   logic [31:0]   ar_prev_addr = '0, aw_prev_addr = '0;
   logic [7:0]    ar_prev_len = '0, aw_prev_len = '0;
   bit            stall = 0, cmd_pending = 0, b_pend = 0;
   bit            r_hold = 0, src_hold = 0, b_hold = 0, ar_wait = 0, aw_wait = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory content; untouched words hold an address-derived pattern
   function automatic logic [DW-1:0] word_at(input logic [31:0] a);
      int unsigned w;
      w = a >> 4;
      if (mem.exists(w)) return mem[w];
      return {w, ~w, w ^ 32'hA5A5_5A5A, w * 32'd2654435761};
   endfunction

   // Reference burst plan: min(remaining, 128, beats left in the 4 KB page)
   task automatic plan(input logic [31:0] a, input int beats);
      int rem, n, page;
      logic [31:0] ad;
      rem = beats + 1;
      ad  = a;
      exp_ax.delete();
      while (rem > 0) begin
         page = (4096 - int'(ad[11:0])) / 16;
         n = rem;
         if (n > 128)  n = 128;
         if (n > page) n = page;
         exp_ax.push_back('{ad, 8'(n - 1)});
         ad  = ad + 32'(n * 16);
         rem = rem - n;
      end
   endtask

   task automatic sample();
      burst_t b;
      if (cmd_valid && cmd_ready) cmd_pending = 0;
      if (arvalid_m_inf) begin
         if (ar_wait) begin
            check("ar_addr_hold", DW'(araddr_m_inf), DW'(ar_prev_addr));
            check("ar_len_hold", DW'(arlen_m_inf), DW'(ar_prev_len));
         end
         ar_prev_addr = araddr_m_inf;
         ar_prev_len  = arlen_m_inf;
         if (arready_m_inf) begin
            check("ar_expected", DW'(exp_ax.size() > 0), DW'(1));
            if (exp_ax.size() > 0) begin
               b = exp_ax.pop_front();
               check("araddr", DW'(araddr_m_inf), DW'(b.addr));
               check("arlen", DW'(arlen_m_inf), DW'(b.len));
            end
            check("arsize", DW'(arsize_m_inf), DW'(4));
            check("arburst_id", DW'({arburst_m_inf, arid_m_inf}), DW'(6'b01_0000));
            r_addr = araddr_m_inf;
            r_left = int'(arlen_m_inf) + 1;
            ar_wait = 0;
         end else ar_wait = 1;
      end else if (ar_wait) begin
         check("ar_dropped", DW'(arvalid_m_inf), DW'(1));
         ar_wait = 0;
      end
      if (awvalid_m_inf) begin
         if (aw_wait) begin
            check("aw_addr_hold", DW'(awaddr_m_inf), DW'(aw_prev_addr));
            check("aw_len_hold", DW'(awlen_m_inf), DW'(aw_prev_len));
         end
         aw_prev_addr = awaddr_m_inf;
         aw_prev_len  = awlen_m_inf;
         if (awready_m_inf) begin
            check("aw_expected", DW'(exp_ax.size() > 0), DW'(1));
            if (exp_ax.size() > 0) begin
               b = exp_ax.pop_front();
               check("awaddr", DW'(awaddr_m_inf), DW'(b.addr));
               check("awlen", DW'(awlen_m_inf), DW'(b.len));
            end
            check("awsize_burst", DW'({awsize_m_inf, awburst_m_inf}), DW'(5'b100_01));
            w_addr = awaddr_m_inf;
            w_left = int'(awlen_m_inf) + 1;
            aw_wait = 0;
         end else aw_wait = 1;
      end else if (aw_wait) begin
         check("aw_dropped", DW'(awvalid_m_inf), DW'(1));
         aw_wait = 0;
      end
      if (rready_m_inf) check("rready_in_r", DW'(r_left > 0), DW'(1));
      if (rvalid_m_inf && rready_m_inf) begin
         check("rd_valid", DW'(rd_valid && rd_ready), DW'(1));
         check("rd_data", rd_data, word_at(base + 32'(rd_idx * 16)));
         check("rd_last", DW'(rd_last), DW'(rd_idx == nbeats - 1));
         rd_idx++;
         r_addr = r_addr + 32'd16;
         r_left--;
         r_hold  = 0;
         last_hs = cyc;
      end else begin
         if (rd_valid && rd_ready) check("rd_phantom", DW'(rready_m_inf), DW'(1));
         r_hold = rvalid_m_inf;
      end
      if (wvalid_m_inf) check("wvalid_after_aw", DW'(w_left > 0), DW'(1));
      if (wr_ready) check("wr_ready_in_w", DW'(w_left > 0), DW'(1));
      if (wvalid_m_inf && wready_m_inf) begin
         check("wdata", wdata_m_inf, (wr_idx < wq.size()) ? wq[wr_idx] : '0);
         check("w_addr", DW'(w_addr), DW'(base + 32'(wr_idx * 16)));
         check("wlast", DW'(wlast_m_inf), DW'(w_left == 1));
         mem[w_addr >> 4] = wdata_m_inf;
         w_addr = w_addr + 32'd16;
         w_left--;
         wr_idx++;
         if (w_left == 0) b_pend = 1;
      end
      if (wr_valid && wr_ready) begin
         wr_src++;
         src_hold = 0;
      end else src_hold = wr_valid;
      if (bvalid_m_inf && bready_m_inf) begin
         b_pend = 0;
         b_hold = 0;
         b_cnt++;
         last_hs = cyc;
      end else b_hold = bvalid_m_inf;
      if (done) begin
         done_cnt++;
         check("done_latency", DW'(cyc), DW'(last_hs + 1));
         check("cmd_ready_at_done", DW'(cmd_ready), DW'(0));
      end
   endtask

   // One clock: drive slave/source at negedge, sample what the next posedge will see
   task automatic cycle();
      @(negedge clk);
      cmd_valid     = cmd_pending;
      arready_m_inf = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      awready_m_inf = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready_m_inf  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!r_hold) rvalid_m_inf = (r_left > 0) && (!stall || $urandom_range(0, 2) != 0);
      rdata_m_inf = word_at(r_addr);
      rlast_m_inf = (r_left == 1);
      rresp_m_inf = 2'b00;
      if (!src_hold) wr_valid = (wr_src < wq.size()) && (!stall || $urandom_range(0, 2) != 0);
      wr_data = (wr_src < wq.size()) ? wq[wr_src] : '0;
      if (!b_hold) bvalid_m_inf = b_pend && (!stall || $urandom_range(0, 1) != 0);
      bresp_m_inf = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      #1;
      sample();
      cyc++;
   endtask

   task automatic start_cmd(input bit wr, input logic [31:0] a, input int beats);
      int guard;
      plan(a, beats);
      base   = a;
      nbeats = beats + 1;
      wq.delete();
      if (wr) for (int i = 0; i < nbeats; i++) wq.push_back({$urandom, $urandom, $urandom, $urandom});
      rd_idx = 0; wr_idx = 0; wr_src = 0; done_cnt = 0; b_cnt = 0;
      cmd_write   = wr;
      cmd_addr    = a;
      cmd_beats   = 12'(beats);
      cmd_pending = 1;
      guard = 0;
      while (cmd_pending && guard < 100) begin
         cycle();
         guard++;
      end
      check("cmd_accept", DW'(cmd_pending), DW'(0));
      cycle();
      check("err_clear_on_accept", DW'(err), DW'(0));
   endtask

   task automatic finish_cmd(input bit exp_err);
      int guard;
      guard = 0;
      while (done_cnt == 0 && guard < 20000) begin
         cycle();
         guard++;
      end
      check("done_seen", DW'(done_cnt), DW'(1));
      check("err_at_done", DW'(err), DW'(exp_err));
      check("bursts_left", DW'(exp_ax.size()), DW'(0));
      check("beat_count", DW'(cmd_write ? wr_idx : rd_idx), DW'(nbeats));
      cycle();
      check("cmd_ready_after", DW'(cmd_ready), DW'(1));
      check("done_one_cycle", DW'(done), DW'(0));
      check("err_sticky", DW'(err), DW'(exp_err));
   endtask

   task automatic run_cmd(input bit wr, input logic [31:0] a, input int beats, input bit exp_err);
      start_cmd(wr, a, beats);
      finish_cmd(exp_err);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats = '0;
      rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
      arready_m_inf = 1'b0; awready_m_inf = 1'b0; wready_m_inf = 1'b0;
      rid_m_inf = '0; bid_m_inf = '0; rdata_m_inf = '0; rresp_m_inf = '0; rlast_m_inf = 1'b0;
      rvalid_m_inf = 1'b0; bresp_m_inf = '0; bvalid_m_inf = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
      check("rst_flags", DW'({done, err, arvalid_m_inf, awvalid_m_inf, wvalid_m_inf, wlast_m_inf,
                              bready_m_inf, rready_m_inf, rd_valid, wr_ready, rd_last}), DW'(0));
      check("rst_addr_len", DW'({araddr_m_inf, awaddr_m_inf, arlen_m_inf, awlen_m_inf}), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd(1'b0, 32'h0000_1000, 15, 1'b0);
      run_cmd(1'b0, 32'h0000_1F80, 15, 1'b0);
      run_cmd(1'b1, 32'h0000_0000, 299, 1'b0);
      run_cmd(1'b0, 32'h0000_0000, 299, 1'b0);

      stall = 1;
      for (int k = 0; k < 6; k++)
         run_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFF0,
                 int'($urandom_range(0, 300)), 1'b0);

      stall = 0;
      err_burst = 1;
      run_cmd(1'b1, 32'h0000_8000, 199, 1'b1);
      err_burst = -1;
      run_cmd(1'b0, 32'h0000_8000, 3, 1'b0);

      // Reset with five read beats still outstanding
      start_cmd(1'b0, 32'h0000_3000, 15);
      guard = 0;
      while (rd_idx < 11 && guard < 1000) begin
         cycle();
         guard++;
      end
      check("reached_mid_read", DW'(rd_idx), DW'(11));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_cmd_ready", DW'(cmd_ready), DW'(1));
      check("midrst_valids", DW'({arvalid_m_inf, awvalid_m_inf, wvalid_m_inf, rd_valid,
                                  rready_m_inf, bready_m_inf, done}), DW'(0));
      r_left = 0; r_hold = 0; rvalid_m_inf = 1'b0; ar_wait = 0; aw_wait = 0;
      exp_ax.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_cmd(1'b0, 32'h0000_3000, 15, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
